// File: rtl/onewire_pkg.sv
// Shared types and timing defaults for the 1-wire responder.
// No logic of its own; timing is expressed in microseconds and scaled to clocks here.
// Not applicable: no datapath.
package onewire_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SLOT       = 3'd1,
        RST_LOW    = 3'd2,
        PRES_WAIT  = 3'd3,
        PRES_DRIVE = 3'd4,
        PRES_REL   = 3'd5
    } ow_state_t;

    localparam int DEF_CLK_PER_US = 65;
    localparam int DEF_T_SAMPLE   = 30;
    localparam int DEF_T_RST_MIN  = 400;
    localparam int DEF_T_PDH      = 30;
    localparam int DEF_T_PDL      = 120;

    function automatic int us2clk(input int us, input int clk_per_us);
        return us * clk_per_us;
    endfunction

endpackage

// File: rtl/onewire_sync.sv
// Two-flop synchroniser for the raw 1-wire line with rise/fall strobes.
// Latency: line valid 2 clk after the pad changes; edge strobes in that same cycle.
// No backpressure: free-running, one strobe per transition.
module onewire_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic line_async,
    output logic line,
    output logic rise,
    output logic fall
);

    logic ff1, ff2, ff2_d;

    // Idle bus is high, so reset to 1 to avoid a phantom falling edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ff1   <= 1'b1;
            ff2   <= 1'b1;
            ff2_d <= 1'b1;
        end else begin
            ff1   <= line_async;
            ff2   <= ff1;
            ff2_d <= ff2;
        end
    end

    assign line = ff2;
    assign rise = ff2 & ~ff2_d;
    assign fall = ~ff2 & ff2_d;

endmodule

// File: rtl/onewire_slave.sv
// 1-wire responder: reset/presence, write-slot deserialiser, read-slot driver.
// Latency: 2 clk line sync; rx_valid/rst_det registered 1 clk after the sync'd rise.
// Backpressure: tx_ready only while idle between bytes with no byte pending.
module onewire_slave
    import onewire_pkg::*;
#(
    parameter int CLK_PER_US = DEF_CLK_PER_US,
    parameter int T_SAMPLE   = DEF_T_SAMPLE,
    parameter int T_RST_MIN  = DEF_T_RST_MIN,
    parameter int T_PDH      = DEF_T_PDH,
    parameter int T_PDL      = DEF_T_PDL
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       owr_i,
    output logic       owr_e,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       rst_det
);

    localparam int SAMPLE_C = us2clk(T_SAMPLE, CLK_PER_US);
    localparam int RST_C    = us2clk(T_RST_MIN, CLK_PER_US);
    localparam int PDH_C    = us2clk(T_PDH, CLK_PER_US);
    localparam int PDL_C    = us2clk(T_PDL, CLK_PER_US);
    localparam int TW       = $clog2(RST_C + 1);

    localparam logic [TW-1:0] SAMPLE_T   = TW'(SAMPLE_C);
    localparam logic [TW-1:0] SAMPLE_END = TW'(SAMPLE_C - 1);
    localparam logic [TW-1:0] RST_T      = TW'(RST_C);
    // PRES_WAIT is entered one cycle after the sync'd rise, so count one less.
    localparam logic [TW-1:0] PDH_END    = TW'(PDH_C - 2);
    localparam logic [TW-1:0] PDL_END    = TW'(PDL_C - 1);

    ow_state_t     state, state_nxt;
    logic [TW-1:0] timer;
    logic [2:0]    bit_cnt;
    logic [7:0]    tx_sh, rx_sh;
    logic          tx_full, bit_val;
    logic          line, rise, fall;
    logic          slot_done, last_bit, bit_now, tx_acc;
    logic          owr_e_nxt, rst_det_nxt;

    onewire_sync u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .line_async (owr_i),
        .line       (line),
        .rise       (rise),
        .fall       (fall)
    );

    assign tx_ready  = ~tx_full & (bit_cnt == 3'd0) & (state == IDLE);
    assign tx_acc    = tx_valid & tx_ready;
    assign slot_done = (state == SLOT) & rise & (timer < RST_T);
    assign last_bit  = (bit_cnt == 3'd7);
    // A release at or before the sample point is a '1'; later releases use the sample.
    assign bit_now   = (timer <= SAMPLE_T) ? 1'b1 : bit_val;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:       if (fall) state_nxt = SLOT;
            SLOT:       if (slot_done) state_nxt = IDLE;
                        else if (timer == RST_T) state_nxt = RST_LOW;
            RST_LOW:    if (line) state_nxt = PRES_WAIT;
            PRES_WAIT:  if (timer == PDH_END) state_nxt = PRES_DRIVE;
            PRES_DRIVE: if (timer == PDL_END) state_nxt = PRES_REL;
            PRES_REL:   if (line) state_nxt = IDLE;
                        else if (timer == RST_T) state_nxt = RST_LOW;
            default:    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        owr_e_nxt   = 1'b0;
        rst_det_nxt = 1'b0;
        case (state)
            IDLE:       owr_e_nxt = fall & tx_full & ~tx_sh[0];
            SLOT:       owr_e_nxt = owr_e & ~slot_done & (timer < SAMPLE_END);
            RST_LOW:    rst_det_nxt = line;
            PRES_WAIT:  owr_e_nxt = (timer == PDH_END);
            PRES_DRIVE: owr_e_nxt = (timer != PDL_END);
            default:    ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timer    <= '0;
            bit_cnt  <= 3'd0;
            tx_sh    <= 8'd0;
            rx_sh    <= 8'd0;
            tx_full  <= 1'b0;
            bit_val  <= 1'b0;
            owr_e    <= 1'b0;
            rx_data  <= 8'd0;
            rx_valid <= 1'b0;
            rst_det  <= 1'b0;
        end else begin
            owr_e    <= owr_e_nxt;
            rst_det  <= rst_det_nxt;
            rx_valid <= 1'b0;

            if (state_nxt != state) timer <= '0;
            else if (timer != RST_T) timer <= timer + TW'(1);

            if (state == SLOT && timer == SAMPLE_T) bit_val <= line;

            if (tx_acc) begin
                tx_sh   <= tx_data;
                tx_full <= 1'b1;
            end

            if (slot_done) begin
                bit_cnt <= bit_cnt + 3'd1;
                if (tx_full) begin
                    tx_sh <= {1'b0, tx_sh[7:1]};
                    if (last_bit) tx_full <= 1'b0;
                end else begin
                    rx_sh <= {bit_now, rx_sh[7:1]};
                    if (last_bit) begin
                        rx_data  <= {bit_now, rx_sh[7:1]};
                        rx_valid <= 1'b1;
                    end
                end
            end

            // A bus reset drops any partial byte in either direction.
            if (rst_det_nxt) begin
                bit_cnt <= 3'd0;
                rx_sh   <= 8'd0;
                tx_full <= 1'b0;
            end
        end
    end

endmodule
